// File: rtl/demux_1xn_stream.sv
// Registered 1-to-N_CH valid/ready stream demultiplexer with broadcast and drop counting.
// Optional per-channel handshake counters (port chan_cnt) enabled by defining DEMUX_STATS_EN.
module demux_1xn_stream #(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 8,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     busy
`ifdef DEMUX_STATS_EN
  ,
  output logic [N_CH*CNT_W-1:0]    chan_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, UNI, BCAST} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_CH-1:0]    pend_q, pend_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               init_q;
  logic [N_CH-1:0]    sel_oh;
  logic               complete;
  logic               accept;
  logic               in_range;

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) init_q <= 1'b0;
    else       init_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    sel_oh = '0;
    for (int unsigned i = 0; i < N_CH; i++) sel_oh[i] = (sel_q == SEL_W'(i));
  end

  assign in_range = ({1'b0, in_sel} < (SEL_W+1)'(N_CH));

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    sel_d     = sel_q;
    pend_d    = pend_q;
    drop_d    = drop_q;
    out_valid = '0;
    complete  = 1'b0;
    unique case (state_q)
      EMPTY: complete = 1'b1;
      UNI: begin
        out_valid = sel_oh;
        complete  = |(sel_oh & out_ready);
      end
      BCAST: begin
        out_valid = pend_q;
        complete  = ((pend_q & ~out_ready) == '0);
        pend_d    = pend_q & ~out_ready;
      end
      default: ;
    endcase
    in_ready = init_q & complete;
    accept   = in_valid & in_ready;
    // A new word overrides the completion transition, so there is no bubble.
    if (accept) begin
      if (in_bcast) begin
        state_d = BCAST;
        pend_d  = '1;
        data_d  = in_data;
      end else if (in_range) begin
        state_d = UNI;
        sel_d   = in_sel;
        data_d  = in_data;
      end else begin
        state_d = EMPTY;
        if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
      end
    end else if (complete && state_q != EMPTY) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) out_data[i*DATA_W +: DATA_W] = data_q;
  end

  assign drop_cnt = drop_q;
  assign busy     = (state_q != EMPTY);

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_CH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++)
        if (out_valid[i] && out_ready[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  always_comb begin
    chan_cnt = '0;
    for (int unsigned i = 0; i < N_CH; i++) chan_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Directed bench for demux_1xn_stream: a default 4-channel instance and a 5-channel
// instance with a 2-bit drop counter for the out-of-range select path.
module tb_demux_1xn_stream;

  logic        clk = 1'b0;
  logic        rstn;
  int          tests = 0;
  int          failed = 0;

  logic        v0, b0, rdy0;
  logic [7:0]  d0;
  logic [1:0]  s0;
  logic [3:0]  ov0, or0;
  logic [31:0] od0;
  logic [7:0]  dc0;
  logic        busy0;

  logic        v1, b1, rdy1;
  logic [7:0]  d1;
  logic [2:0]  s1;
  logic [4:0]  ov1, or1;
  logic [39:0] od1;
  logic [1:0]  dc1;
  logic        busy1;

`ifdef DEMUX_STATS_EN
  logic [31:0] cc0;
  logic [9:0]  cc1;
`endif

  always #5 clk = ~clk;

  demux_1xn_stream u0 (
    .clk(clk), .rstn(rstn), .in_valid(v0), .in_ready(rdy0), .in_data(d0), .in_sel(s0),
    .in_bcast(b0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .drop_cnt(dc0),
    .busy(busy0)
`ifdef DEMUX_STATS_EN
    , .chan_cnt(cc0)
`endif
  );

  demux_1xn_stream #(.N_CH(5), .DATA_W(8), .CNT_W(2)) u1 (
    .clk(clk), .rstn(rstn), .in_valid(v1), .in_ready(rdy1), .in_data(d1), .in_sel(s1),
    .in_bcast(b1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .drop_cnt(dc1),
    .busy(busy1)
`ifdef DEMUX_STATS_EN
    , .chan_cnt(cc1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_drop [6] = '{1, 2, 3, 3, 3, 3};
    rstn = 1'b0;
    v0 = 0; b0 = 0; d0 = '0; s0 = '0; or0 = '0;
    v1 = 0; b1 = 0; d1 = '0; s1 = '0; or1 = '1;

    #12;
    chk("rst_out_valid", 64'(ov0), 64'h0);
    chk("rst_out_data",  64'(od0), 64'h0);
    chk("rst_drop_cnt",  64'(dc0), 64'h0);
    chk("rst_busy",      64'(busy0), 64'h0);
    chk("rst_in_ready",  64'(rdy0), 64'h0);
    #10 rstn = 1'b1;
    #1;
    chk("rel_in_ready_low", 64'(rdy0), 64'h0);
    tick();
    chk("rel_in_ready_high", 64'(rdy0), 64'h1);

    // Single unicast to ch2
    v0 = 1; s0 = 2; d0 = 8'hA5; or0 = 4'b1111;
    #1;
    chk("t1_in_ready", 64'(rdy0), 64'h1);
    tick();
    v0 = 0;
    chk("t1_out_valid", 64'(ov0), 64'b0100);
    chk("t1_lane2",     64'(od0[16 +: 8]), 64'hA5);
    chk("t1_busy",      64'(busy0), 64'h1);
    tick();
    chk("t1_out_valid_clr", 64'(ov0), 64'h0);
    chk("t1_busy_clr",      64'(busy0), 64'h0);

    // Backpressured unicast to ch1, then no-bubble handover
    v0 = 1; s0 = 1; d0 = 8'h3C; or0 = 4'b0000;
    tick();
    s0 = 3; d0 = 8'h55;
    for (int k = 0; k < 5; k++) begin
      chk("t2_in_ready_low", 64'(rdy0), 64'h0);
      chk("t2_out_valid",    64'(ov0), 64'b0010);
      chk("t2_lane1",        64'(od0[8 +: 8]), 64'h3C);
      tick();
    end
    or0 = 4'b0010;
    #1;
    chk("t2_in_ready_high", 64'(rdy0), 64'h1);
    tick();
    v0 = 0;
    chk("t2_next_valid", 64'(ov0), 64'b1000);
    chk("t2_lane3",      64'(od0[24 +: 8]), 64'h55);
    or0 = 4'b1111;
    tick();
    chk("t2_drain", 64'(ov0), 64'h0);

    // Broadcast with channels accepting in order 3,0,2,1
    v0 = 1; b0 = 1; d0 = 8'h77; or0 = 4'b0000;
    tick();
    v0 = 0; b0 = 0;
    chk("t3_valid_1111", 64'(ov0), 64'b1111);
    chk("t3_data_all",   64'(od0), 64'h77777777);
    chk("t3_rdy_idle",   64'(rdy0), 64'h0);
    or0 = 4'b1000; #1; chk("t3_rdy_ch3", 64'(rdy0), 64'h0);
    tick(); chk("t3_valid_0111", 64'(ov0), 64'b0111);
    or0 = 4'b0001; #1; chk("t3_rdy_ch0", 64'(rdy0), 64'h0);
    tick(); chk("t3_valid_0110", 64'(ov0), 64'b0110);
    or0 = 4'b0100; #1; chk("t3_rdy_ch2", 64'(rdy0), 64'h0);
    tick(); chk("t3_valid_0010", 64'(ov0), 64'b0010);
    or0 = 4'b0010; #1; chk("t3_rdy_ch1", 64'(rdy0), 64'h1);
    tick(); chk("t3_valid_0000", 64'(ov0), 64'b0000);
    chk("t3_busy", 64'(busy0), 64'h0);

    // Back-to-back stream 0..15
    or0 = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      v0 = 1; d0 = 8'(i); s0 = 2'(i % 4);
      #1;
      chk("t4_in_ready", 64'(rdy0), 64'h1);
      tick();
      chk("t4_out_valid", 64'(ov0), 64'(4'b0001 << (i % 4)));
      chk("t4_lane_data", 64'(od0[(i % 4)*8 +: 8]), 64'(i));
    end
    v0 = 0;
    tick();
    chk("t4_idle", 64'(ov0), 64'h0);

    // Out-of-range select drops on the 5-channel instance
    for (int k = 0; k < 6; k++) begin
      v1 = 1; s1 = 3'd6; d1 = 8'(k);
      tick();
      chk("t5_no_valid", 64'(ov1), 64'h0);
      chk("t5_drop_cnt", 64'(dc1), 64'(exp_drop[k]));
    end
    s1 = 3'd4; d1 = 8'h9E;
    tick();
    v1 = 0;
    chk("t5_ch4_valid", 64'(ov1), 64'b10000);
    chk("t5_ch4_data",  64'(od1[32 +: 8]), 64'h9E);
    chk("t5_drop_hold", 64'(dc1), 64'h3);
    tick();
    chk("t5_ch4_drain", 64'(ov1), 64'h0);

    // Asynchronous reset in the middle of a broadcast
    v0 = 1; b0 = 1; d0 = 8'h11; or0 = 4'b0000;
    tick();
    v0 = 0; b0 = 0; or0 = 4'b0101;
    tick();
    or0 = 4'b0000;
    chk("t6_pend_1010", 64'(ov0), 64'b1010);
    chk("t6_busy_pre",  64'(busy0), 64'h1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_out_valid", 64'(ov0), 64'h0);
    chk("t6_busy",      64'(busy0), 64'h0);
    chk("t6_drop_cnt",  64'(dc1), 64'h0);
    chk("t6_out_data",  64'(od0), 64'h0);
`ifdef DEMUX_STATS_EN
    chk("t6_chan_cnt0", 64'(cc0), 64'h0);
    chk("t6_chan_cnt1", 64'(cc1), 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
